// File: rtl/controlador_aleatorio.sv
// Shared random-number service: a free-running 32-bit LFSR, a round-robin
// arbiter, and a 16-step restoring remainder unit that reduces a sample modulo each requester's limit.
module controlador_aleatorio #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] limite,
  output logic [7:0]     valor,
  output logic [N-1:0]   ack,
  output logic           ocupado
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {OCIOSO, REDUZ, ENTREGA} estado_t;

  estado_t       estado, proximo;
  logic [31:0]   lfsr;
  logic [IW-1:0] ultimo, concedido, escolha, idx_busca;
  logic [15:0]   amostra;
  logic [8:0]    divisor, resto, resto_prox;
  logic [3:0]    passo;
  logic [7:0]    limite_escolhido;
  logic [9:0]    parcial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:  if (|req) proximo = REDUZ;
      REDUZ:   if (passo == 4'd15) proximo = ENTREGA;
      ENTREGA: proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado != OCIOSO);
    ack     = '0;
    if (estado == ENTREGA) ack[concedido] = 1'b1;
  end

  // The LFSR never stalls, so request timing itself adds entropy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 32'h0000_0013;
    else        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  end

  // Scan downward so the closest requester after ultimo is the last to overwrite.
  always_comb begin
    escolha   = ultimo;
    idx_busca = '0;
    for (int off = N; off >= 1; off--) begin
      idx_busca = IW'((int'(ultimo) + off) % N);
      if (req[idx_busca]) escolha = idx_busca;
    end
  end

  assign limite_escolhido = limite[{escolha, 3'b000} +: 8];

  always_comb begin
    parcial    = {resto, amostra[4'd15 - passo]};
    resto_prox = (parcial >= {1'b0, divisor}) ? 9'(parcial - {1'b0, divisor}) : parcial[8:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ultimo    <= IW'(N - 1);
      concedido <= '0;
      amostra   <= '0;
      divisor   <= 9'd1;
      resto     <= '0;
      passo     <= '0;
      valor     <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (|req) begin
            concedido <= escolha;
            ultimo    <= escolha;
            amostra   <= lfsr[31:16];
            divisor   <= {limite_escolhido == 8'd0, limite_escolhido};
            resto     <= '0;
            passo     <= '0;
          end
        end
        REDUZ: begin
          resto <= resto_prox;
          passo <= passo + 4'd1;
          if (passo == 4'd15) valor <= resto_prox[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule
